spart_driver: RTL and testbench

Bus-master counterpart to the SPART peripheral: drives the chip-select/read-write/address/tristate data bus to program the baud divisor, poll status, read received bytes and write them back for transmission (echo). Sits between the board-level baud switches and the SPART bus port. Received bytes are decoupled from transmission by a small FIFO, so bursts are not lost while the transmitter is busy.

---
 rtl/spart_driver.sv | 216 +++++++++++++++++++++
 tb/tb_spart_driver.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/spart_driver.sv
// spart_driver: bus master for the SPART peripheral. Programs the baud divisor from the
// board switches, polls status every idle cycle, reads received bytes into a small echo
// FIFO and writes them back to the transmitter.
//
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   br_cfg_i       baud select (00=4800, 01=9600, 10=19200, 11=38400)
//   iocs_o         SPART chip select (one bus cycle per clock once running)
//   iorw_o         1 = read from SPART, 0 = write to SPART
//   ioaddr_o       SPART register address
//   databus_io     shared data bus, driven here only on write cycles
//   rda_i, tbr_i   receive-data-available / transmit-buffer-ready status pins
//   fifo_count_o   echo FIFO occupancy
//
// Build option: define SPART_DRV_STATUS_BUS_EN to take RDA/TBR from the status byte on
// databus_io[1:0] instead of the rda_i/tbr_i pins.

module spart_driver #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TX_HOLDOFF = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [1:0]                    br_cfg_i,
  output logic                          iocs_o,
  output logic                          iorw_o,
  output logic [1:0]                    ioaddr_o,
  inout  wire  [7:0]                    databus_io,
  input  logic                          rda_i,
  input  logic                          tbr_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned HoldW = (TX_HOLDOFF > 0) ? $clog2(TX_HOLDOFF + 1) : 1;

  localparam logic [1:0] AddrData   = 2'b00;
  localparam logic [1:0] AddrStatus = 2'b01;
  localparam logic [1:0] AddrDivLo  = 2'b10;
  localparam logic [1:0] AddrDivHi  = 2'b11;

  typedef enum logic [2:0] {
    StCfgLo,
    StCfgHi,
    StIdle,
    StRxRead,
    StTxWrite
  } state_e;

  state_e             state_q, state_d;
  logic               en_q;
  logic [1:0]         cfg_q, cfg_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    count_q, count_d;
  logic [7:0]         mem_q [FIFO_DEPTH];

  logic               full, empty, push, pop;
  logic               rda, tbr;
  logic               iorw, drive;
  logic [1:0]         addr;
  logic [7:0]         dout;
  logic [15:0]        div_new, div_cur;

  // Divisor register value equals the baud rate in bits/s.
  function automatic logic [15:0] divisor(input logic [1:0] sel);
    logic [15:0] d;
    unique case (sel)
      2'b00:   d = 16'h12C0;
      2'b01:   d = 16'h2580;
      2'b10:   d = 16'h4B00;
      default: d = 16'h9600;
    endcase
    return d;
  endfunction

  assign div_new = divisor(br_cfg_i);
  assign div_cur = divisor(cfg_q);

  assign full  = (count_q == CntW'(FIFO_DEPTH));
  assign empty = (count_q == '0);

`ifdef SPART_DRV_STATUS_BUS_EN
  assign rda = databus_io[0];
  assign tbr = databus_io[1];
`else
  assign rda = rda_i;
  assign tbr = tbr_i;
`endif

  // en_q holds the bus idle for the reset cycle so the first edge after release opens
  // the CFG_LO bus cycle with iocs low until then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q    <= 1'b0;
      state_q <= StCfgLo;
    end else begin
      en_q <= 1'b1;
      if (en_q) begin
        state_q <= state_d;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StCfgLo:   state_d = StCfgHi;
      StCfgHi:   state_d = StIdle;
      StIdle: begin
        if (br_cfg_i != cfg_q) begin
          state_d = StCfgLo;
        end else if (rda && !full) begin
          state_d = StRxRead;
        end else if (tbr && !empty && (hold_q == '0)) begin
          state_d = StTxWrite;
        end
      end
      StRxRead:  state_d = StIdle;
      StTxWrite: state_d = StIdle;
      default:   state_d = StCfgLo;
    endcase
  end

  always_comb begin
    iorw = 1'b1;
    addr = AddrData;
    dout = 8'h00;
    unique case (state_q)
      StCfgLo: begin
        iorw = 1'b0;
        addr = AddrDivLo;
        dout = div_new[7:0];
      end
      StCfgHi: begin
        iorw = 1'b0;
        addr = AddrDivHi;
        dout = div_cur[15:8];
      end
      StIdle:   addr = AddrStatus;
      StRxRead: addr = AddrData;
      StTxWrite: begin
        iorw = 1'b0;
        addr = AddrData;
        dout = mem_q[rd_ptr_q];
      end
      default: ;
    endcase
  end

  assign iocs_o     = en_q;
  assign iorw_o     = en_q ? iorw : 1'b1;
  assign ioaddr_o   = en_q ? addr : 2'b00;
  assign drive      = en_q && !iorw;
  assign databus_io = drive ? dout : 8'hzz;

  // Datapath next state: FIFO occupancy, TX holdoff, latched baud select.
  assign push = en_q && (state_q == StRxRead);
  assign pop  = en_q && (state_q == StTxWrite);

  always_comb begin
    count_d = count_q;
    if (push) begin
      count_d = count_q + CntW'(1);
    end else if (pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_comb begin
    hold_d = hold_q;
    if (pop) begin
      hold_d = HoldW'(TX_HOLDOFF);
    end else if (en_q && (state_q == StIdle) && (hold_q != '0)) begin
      hold_d = hold_q - HoldW'(1);
    end
  end

  always_comb begin
    cfg_d = cfg_q;
    if (en_q && (state_q == StCfgLo)) begin
      cfg_d = br_cfg_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      hold_q   <= '0;
      cfg_q    <= 2'b00;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q <= count_d;
      hold_q  <= hold_d;
      cfg_q   <= cfg_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  // Storage needs no reset: count_q and the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= databus_io;
    end
  end

  assign fifo_count_o = count_q;

endmodule

// File: tb/tb_spart_driver.sv
module tb_spart_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] br_cfg = 2'b01;
  logic       iocs, iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic       rda;
  logic       tbr = 1'b0;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;

  // SPART model: RX byte source written by the stimulus, consumed on RX_READ cycles.
  logic [7:0] rx_mem [0:31];
  int         rx_wr = 0;
  int         rx_rd = 0;
  logic [7:0] bus_rd;

  // Logs filled at each closing edge.
  int         cyc = 0;
  logic [7:0] tx_data [0:63];
  int         tx_cyc  [0:63];
  int         tx_n = 0;
  logic [1:0] cfg_addr [0:63];
  logic [7:0] cfg_data [0:63];
  int         cfg_n = 0;
  int         rd_cyc [0:63];
  int         rd_n = 0;

  always #10 clk = ~clk;

  spart_driver #(
    .FIFO_DEPTH(4),
    .TX_HOLDOFF(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .br_cfg_i    (br_cfg),
    .iocs_o      (iocs),
    .iorw_o      (iorw),
    .ioaddr_o    (ioaddr),
    .databus_io  (databus),
    .rda_i       (rda),
    .tbr_i       (tbr),
    .fifo_count_o(fifo_count)
  );

  assign rda     = (rx_wr != rx_rd);
  assign bus_rd  = (ioaddr == 2'b00) ? rx_mem[rx_rd[4:0]] : {6'b0, tbr, rda};
  assign databus = (iocs && iorw) ? bus_rd : 8'hzz;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (iocs && !iorw) begin
      if (ioaddr == 2'b00) begin
        tx_data[tx_n] <= databus;
        tx_cyc[tx_n]  <= cyc;
        tx_n          <= tx_n + 1;
      end else begin
        cfg_addr[cfg_n] <= ioaddr;
        cfg_data[cfg_n] <= databus;
        cfg_n           <= cfg_n + 1;
      end
    end
    if (iocs && iorw && (ioaddr == 2'b00)) begin
      rd_cyc[rd_n] <= cyc;
      rd_n         <= rd_n + 1;
      rx_rd        <= rx_rd + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_mem[rx_wr[4:0]] = b;
    rx_wr = rx_wr + 1;
  endtask

  task automatic wait_tx(input int target, input int budget);
    int k = 0;
    while (tx_n < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("tx_wait", 32'(tx_n >= target), 32'd1);
  endtask

  task automatic check_bus(input string tag, input logic rw, input logic [1:0] a,
                           input logic [7:0] d, input logic chk_d);
    check({tag, "_cs"}, 32'(iocs), 32'd1);
    check({tag, "_rw"}, 32'(iorw), 32'(rw));
    check({tag, "_addr"}, 32'(ioaddr), 32'(a));
    if (chk_d) check({tag, "_data"}, 32'(databus), 32'(d));
  endtask

  initial begin
    int k, rd0, tx0;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cs", 32'(iocs), 32'd0);
    check("rst_rw", 32'(iorw), 32'd1);
    check("rst_addr", 32'(ioaddr), 32'd0);
    check("rst_cnt", 32'(fifo_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_bus("cfg_lo", 1'b0, 2'b10, 8'h80, 1'b1);
    @(negedge clk);
    check_bus("cfg_hi", 1'b0, 2'b11, 8'h25, 1'b1);
    @(negedge clk);
    check_bus("idle", 1'b1, 2'b01, 8'h00, 1'b0);

    // Single byte echo
    tbr = 1'b1;
    repeat (2) @(negedge clk);
    k = cyc; rd0 = rd_n; tx0 = tx_n;
    push_rx(8'h5A);
    repeat (2) @(negedge clk);
    check("one_rd_cyc", 32'(rd_cyc[rd0] - k), 32'd1);
    check("one_cnt1", 32'(fifo_count), 32'd1);
    wait_tx(tx0 + 1, 20);
    check("one_tx_cyc", 32'(tx_cyc[tx0] - k), 32'd3);
    check("one_tx_data", 32'(tx_data[tx0]), 32'h5A);
    @(negedge clk);
    check("one_cnt0", 32'(fifo_count), 32'd0);

    // Burst of six with TX blocked: FIFO fills, remainder stays pending
    tbr = 1'b0;
    repeat (4) @(negedge clk);
    rd0 = rd_n; tx0 = tx_n;
    for (int i = 1; i <= 6; i++) push_rx(8'(i));
    repeat (20) @(negedge clk);
    check("full_cnt", 32'(fifo_count), 32'd4);
    check("full_reads", 32'(rd_n - rd0), 32'd4);
    check("full_pending", 32'(rx_wr - rx_rd), 32'd2);
    tbr = 1'b1;
    wait_tx(tx0 + 6, 200);
    for (int i = 0; i < 6; i++) check("burst_data", 32'(tx_data[tx0 + i]), 32'(i + 1));
    for (int i = 1; i < 6; i++)
      check("burst_gap", 32'((tx_cyc[tx0 + i] - tx_cyc[tx0 + i - 1]) >= 4), 32'd1);
    repeat (2) @(negedge clk);
    check("burst_cnt0", 32'(fifo_count), 32'd0);

    // Reconfiguration with one byte held in the FIFO
    tbr = 1'b0;
    push_rx(8'h77);
    repeat (4) @(negedge clk);
    check("recfg_cnt_pre", 32'(fifo_count), 32'd1);
    br_cfg = 2'b11;
    @(negedge clk);
    check_bus("recfg_lo", 1'b0, 2'b10, 8'h00, 1'b1);
    @(negedge clk);
    check_bus("recfg_hi", 1'b0, 2'b11, 8'h96, 1'b1);
    @(negedge clk);
    check_bus("recfg_idle", 1'b1, 2'b01, 8'h00, 1'b0);
    check("recfg_cnt_post", 32'(fifo_count), 32'd1);
    tx0 = tx_n;
    tbr = 1'b1;
    wait_tx(tx0 + 1, 20);
    check("recfg_echo", 32'(tx_data[tx0]), 32'h77);

    // RX wins over TX when both are possible
    tbr = 1'b0;
    repeat (4) @(negedge clk);
    push_rx(8'h11);
    repeat (4) @(negedge clk);
    check("prio_cnt", 32'(fifo_count), 32'd1);
    k = cyc; rd0 = rd_n; tx0 = tx_n;
    push_rx(8'h22);
    tbr = 1'b1;
    wait_tx(tx0 + 1, 20);
    check("prio_rd_cyc", 32'(rd_cyc[rd0] - k), 32'd1);
    check("prio_tx_cyc", 32'(tx_cyc[tx0] - k), 32'd3);
    check("prio_tx_data", 32'(tx_data[tx0]), 32'h11);
    wait_tx(tx0 + 2, 20);
    check("prio_tx2_data", 32'(tx_data[tx0 + 1]), 32'h22);

    // Reset asserted in the middle of a TX write
    tbr = 1'b0;
    repeat (4) @(negedge clk);
    push_rx(8'h33);
    repeat (4) @(negedge clk);
    check("rstx_cnt_pre", 32'(fifo_count), 32'd1);
    tbr = 1'b1;
    tx0 = tx_n;
    @(negedge clk);
    check_bus("rstx_tx", 1'b0, 2'b00, 8'h33, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rstx_cs", 32'(iocs), 32'd0);
    check("rstx_rw", 32'(iorw), 32'd1);
    check("rstx_cnt", 32'(fifo_count), 32'd0);
    @(negedge clk);
    check("rstx_nolog", 32'(tx_n), 32'(tx0));
    rst_n = 1'b1;
    @(negedge clk);
    check_bus("rstx_lo", 1'b0, 2'b10, 8'h00, 1'b1);
    @(negedge clk);
    check_bus("rstx_hi", 1'b0, 2'b11, 8'h96, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
